// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external adder between two requesters, with a one-entry response register; optional subtract mode under ADDER_ARBITER_SUB_EN
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_cin,
    input  logic             req1_cin,
`ifdef ADDER_ARBITER_SUB_EN
    input  logic             req0_sub,
    input  logic             req1_sub,
`endif
    output logic             req0_ready,
    output logic             req1_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    input  logic             rsp_ready
);
    logic             valid_q, valid_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             last_q, last_d;
    logic             accept, gnt0, gnt1, grant, sub;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;

    // Grant: a tie goes to whichever requester was not granted last; no grant while reset is held
    always_comb begin
        accept = ~reset & (~valid_q | rsp_ready);
        gnt0   = accept & req0_valid & (~req1_valid | last_q);
        gnt1   = accept & req1_valid & (~req0_valid | ~last_q);
        grant  = gnt0 | gnt1;
    end

    // Operand steering: requester 0 is the idle default so the adder inputs stay stable
    always_comb begin
        b_sel   = gnt1 ? req1_b : req0_b;
        cin_sel = gnt1 ? req1_cin : req0_cin;
`ifdef ADDER_ARBITER_SUB_EN
        sub     = gnt1 ? req1_sub : req0_sub;
`else
        sub     = 1'b0;
`endif
        add_a   = gnt1 ? req1_a : req0_a;
        add_b   = sub ? ~b_sel : b_sel;
        add_cin = sub | cin_sel;
    end

    // Next state: load on grant, otherwise hold fields; empty once drained with nothing granted
    always_comb begin
        valid_d = grant | (valid_q & ~rsp_ready);
        id_d    = grant ? gnt1 : id_q;
        sum_d   = grant ? add_sum : sum_q;
        cout_d  = grant ? add_cout : cout_q;
        last_d  = grant ? gnt1 : last_q;
    end

    // Response and round-robin state; reset makes requester 0 win the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            last_q  <= last_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = valid_q;
    assign rsp_id     = id_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of adder_arbiter with a behavioural external adder
module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req1_cin;
    logic        req0_sub, req1_sub;
    logic        req0_ready, req1_ready;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        rsp_valid, rsp_id, rsp_cout, rsp_ready;
    logic [31:0] rsp_sum;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    adder_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
`ifdef ADDER_ARBITER_SUB_EN
        .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_ready(rsp_ready)
    );

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rsp(input string tag, input logic v, input logic id, input logic [31:0] s, input logic c);
        chk({tag, "_valid"}, {32'd0, rsp_valid}, {32'd0, v});
        chk({tag, "_id"}, {32'd0, rsp_id}, {32'd0, id});
        chk({tag, "_sum"}, {1'b0, rsp_sum}, {1'b0, s});
        chk({tag, "_cout"}, {32'd0, rsp_cout}, {32'd0, c});
    endtask

    task automatic rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_rdy0"}, {32'd0, req0_ready}, {32'd0, r0});
        chk({tag, "_rdy1"}, {32'd0, req1_ready}, {32'd0, r1});
    endtask

    task automatic edge2;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_cin = 0; req1_cin = 0; req0_sub = 0; req1_sub = 0;
        rsp_ready = 1'b1;
        #3;
        rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);
        rdy("reset", 1'b0, 1'b0);
        #9;
        reset = 1'b0;
        req1_valid = 1'b0;
        req0_a = 5; req0_b = 7; req0_cin = 0;
        #1;
        rdy("single", 1'b1, 1'b0);
        chk("single_add_a", {1'b0, add_a}, 33'd5);
        edge2;
        req0_valid = 1'b0;
        rsp("single", 1'b1, 1'b0, 32'd12, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        rsp("rst_full", 1'b0, 1'b0, 32'd0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 10; req0_b = 1; req0_cin = 0;
        req1_a = 20; req1_b = 2; req1_cin = 1;
        #1;
        rdy("rst_hold", 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            rdy("rr", k[0] == 1'b0, k[0] == 1'b1);
            edge2;
            rsp("rr", 1'b1, k[0], k[0] ? 32'd23 : 32'd11, 1'b0);
            #1;
        end
        req0_valid = 1'b0;
        req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_cin = 0;
        #1;
        rdy("lone1", 1'b0, 1'b1);
        edge2;
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            rdy("stall", 1'b0, 1'b0);
            rsp("stall", 1'b1, 1'b1, 32'd0, 1'b1);
            edge2;
        end
        rsp("stall_end", 1'b1, 1'b1, 32'd0, 1'b1);
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        req0_a = 1; req0_b = 2; req0_cin = 1;
        #1;
        rdy("refill", 1'b1, 1'b0);
        edge2;
        rsp("refill", 1'b1, 1'b0, 32'd4, 1'b0);
        req0_valid = 1'b0;
        edge2;
        rsp("drain", 1'b0, 1'b0, 32'd4, 1'b0);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 7; req1_b = 8; req1_cin = 0;
        #1;
        rdy("empty_tie", 1'b0, 1'b1);
        edge2;
        rsp("empty_tie", 1'b1, 1'b1, 32'd15, 1'b0);
`ifdef ADDER_ARBITER_SUB_EN
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        req0_a = 10; req0_b = 3; req0_cin = 0; req0_sub = 1;
        edge2;
        rsp("sub_pos", 1'b1, 1'b0, 32'd7, 1'b1);
        req0_a = 3; req0_b = 10;
        edge2;
        rsp("sub_neg", 1'b1, 1'b0, 32'hFFFF_FFF9, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand and sum width in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 Port: req0_a, req0_b, req1_a, req1_b  input  WIDTH each  requester N operands.
REQ-006 Port: req0_cin, req1_cin  input  1 each  requester N carry-in.
REQ-007 Port: req0_ready, req1_ready  output  1 each  requester N operation accepted this cycle.
REQ-008 Port: add_a, add_b  output  WIDTH each  operands driven to the shared adder.
REQ-009 Port: add_cin  output  1  carry-in driven to the shared adder.
REQ-010 Port: add_sum  input  WIDTH; add_cout  input  1  combinational adder result, same cycle.
REQ-011 Port: rsp_valid  output  1  response register holds a result.
REQ-012 Port: rsp_id  output  1  requester that owns the response (0 or 1).
REQ-013 Port: rsp_sum  output  WIDTH; rsp_cout  output  1  registered result.
REQ-014 Port: rsp_ready  input  1  consumer takes the response this cycle.

Function
REQ-015 Block SHALL time-share one external adder between two requesters; exactly one operation is granted per cycle at most.
REQ-016 State SHALL be EMPTY (rsp_valid=0) or FULL (rsp_valid=1); single-entry response register.
REQ-017 Accept condition SHALL be: EMPTY, or FULL with rsp_ready=1 (drain and refill same cycle).
REQ-018 When accept condition holds and exactly one reqN_valid=1, that requester SHALL be granted.
REQ-019 When both valid, grant SHALL go to the requester not granted last (round-robin via last_grant register).
REQ-020 reqN_ready SHALL be 1 only in the cycle requester N is granted; combinational on valids, state, rsp_ready, last_grant.
REQ-021 add_a/add_b/add_cin SHALL carry the granted requester's operands; with no grant, requester 0's operands (don't-care, but stable).
REQ-022 On grant, rsp_sum/rsp_cout/rsp_id SHALL load add_sum/add_cout/granted index at the clock edge; rsp_valid=1 next cycle (latency 1).
REQ-023 FULL with rsp_ready=0: all reqN_ready=0, response fields SHALL hold unchanged.
REQ-024 FULL with rsp_ready=1 and no valid request: next state EMPTY; rsp_sum/rsp_cout/rsp_id hold last value.
REQ-025 last_grant SHALL update only on a grant; a lone requester grant also updates it.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; carry-out of the MSB reported in rsp_cout, no overflow flag.

Reset
REQ-027 reset=1 SHALL immediately force: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=1 (requester 0 wins first tie).
REQ-028 Reset mid-operation SHALL discard any held response; no grant is issued while reset=1 (reqN_ready=0).
REQ-029 First grant SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro ADDER_ARBITER_SUB_EN defined: ports req0_sub, req1_sub (input, 1 each) SHALL exist; granted sub=1 drives add_b=~b and add_cin=1 (cin ignored), yielding a-b.
REQ-031 Macro undefined: no sub ports; add_b=b, add_cin=cin always.

Verification
REQ-032 Reset, req0 a=5 b=7 cin=0 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=12, rsp_cout=0.
REQ-033 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; first grant to 0; one response per cycle.
REQ-034 req1 a=0xFFFFFFFF b=1 cin=0, rsp_ready=0 for 3 cycles -> rsp_sum=0, rsp_cout=1 held 3 cycles, reqN_ready=0 throughout.
REQ-035 Response FULL, rsp_ready=1, req0 a=1 b=2 cin=1 same cycle -> old response drained, next cycle rsp_sum=4, no bubble.
REQ-036 reset asserted while FULL -> rsp_valid=0 without clock edge; after release both valid -> requester 0 granted.
REQ-037 With ADDER_ARBITER_SUB_EN: req0 a=10 b=3 sub=1 -> rsp_sum=7, rsp_cout=1; a=3 b=10 sub=1 -> rsp_sum=0xFFFFFFF9, rsp_cout=0.
